// File: rtl/ssc_dist_stream.sv
// ssc_dist_stream
// Distance-stream transmitter for the top-K insertion sorter. Each command
// carries one center point and a count of candidates. Every candidate becomes
// one {Idx, Dist} beat on the Lop channel. Dist is the squared Euclidean
// distance, saturated below all-ones. The final beat of a command is marked
// with LopLast.
//
// Handshake semantics (all three channels: Cmd, Crd, Lop):
//   A transfer happens on a rising clock edge where valid and ready are both
//   high. The producer must hold its payload stable while valid is high and
//   ready is low. Ready never depends on valid here: Cmd_Rdy and Crd_Rdy
//   depend only on state and on the output stall. The Lop producer (this
//   block) keeps Lop, LopVld and LopLast stable while LopVld is high and
//   LopRdy is low.
//
// Pipeline: RUN-state accept -> stage 1 (absolute differences) -> stage 2
// (square, sum, saturate; drives the outputs). A single enable,
// en = !LopVld | LopRdy, advances both stages together. A stall from the
// sorter therefore freezes the whole pipe and no beat is lost or duplicated.
module ssc_dist_stream #(
  parameter int COORD_WIDTH = 8,
  parameter int NUM_COORD   = 3,
  parameter int IDX_WIDTH   = 10,
  parameter int DIST_WIDTH  = 17
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 Cmd_Vld,
  output logic                                 Cmd_Rdy,
  input  logic [COORD_WIDTH*NUM_COORD-1:0]     Cmd_Crd,
  input  logic [IDX_WIDTH-1:0]                 Cmd_BaseIdx,
  input  logic [IDX_WIDTH-1:0]                 Cmd_Num,
  input  logic                                 Crd_Vld,
  output logic                                 Crd_Rdy,
  input  logic [COORD_WIDTH*NUM_COORD-1:0]     Crd,
  output logic [IDX_WIDTH+DIST_WIDTH-1:0]      SSCINS_Lop,
  output logic                                 SSCINS_LopVld,
  output logic                                 SSCINS_LopLast,
  input  logic                                 SSCINS_LopRdy,
  output logic                                 Busy
);

  localparam int PW    = COORD_WIDTH * NUM_COORD;
  // Full-precision width of the sum of squares.
  localparam int SUM_W = 2 * COORD_WIDTH + $clog2(NUM_COORD);
  // Working width: wide enough for the full sum and for the saturation limit,
  // plus one spare bit so the limit never overflows.
  localparam int EXT_W = ((SUM_W > DIST_WIDTH) ? SUM_W : DIST_WIDTH) + 1;

  // Sums at or above all-ones clamp to all-ones minus one. All-ones is the
  // sorter's "empty slot" marker, so a far point must still compare below it.
  localparam logic [EXT_W-1:0]      SAT_LIM  = (EXT_W'(1) << DIST_WIDTH) - EXT_W'(1);
  localparam logic [DIST_WIDTH-1:0] DIST_SAT = {{(DIST_WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Command context.
  logic [PW-1:0]         center;
  logic [IDX_WIDTH-1:0]  idx;
  logic [IDX_WIDTH-1:0]  rem;

  // Stage 1 registers.
  logic                  s1_vld;
  logic                  s1_last;
  logic [IDX_WIDTH-1:0]  s1_idx;
  logic [PW-1:0]         s1_diff;

  // Stage 2 registers; these drive the outputs directly.
  logic                  lop_vld;
  logic                  lop_last;
  logic [IDX_WIDTH-1:0]  lop_idx;
  logic [DIST_WIDTH-1:0] lop_dist;

  // Handshake qualifiers.
  logic                  en;
  logic                  cmd_fire;
  logic                  crd_fire;
  logic                  lop_fire;

  // Combinational datapath values.
  logic [PW-1:0]         crd_diff;
  logic [EXT_W-1:0]      sum_ext;
  logic [DIST_WIDTH-1:0] dist_next;

  assign en       = !lop_vld || SSCINS_LopRdy;
  assign cmd_fire = (state == ST_IDLE) && Cmd_Vld;
  assign crd_fire = (state == ST_RUN) && en && Crd_Vld;
  assign lop_fire = lop_vld && SSCINS_LopRdy;

  // Next-state logic for the command FSM.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (Cmd_Vld) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (crd_fire && (rem == '0)) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (lop_fire && lop_last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Command context: latch on accept, then step once per accepted candidate.
  // idx wraps naturally modulo 2^IDX_WIDTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      center <= '0;
      idx    <= '0;
      rem    <= '0;
    end else if (cmd_fire) begin
      center <= Cmd_Crd;
      idx    <= Cmd_BaseIdx;
      rem    <= Cmd_Num;
    end else if (crd_fire && (rem != '0)) begin
      rem <= rem - IDX_WIDTH'(1);
      idx <= idx + IDX_WIDTH'(1);
    end
  end

  // Per-coordinate absolute difference between the candidate and the center.
  for (genvar j = 0; j < NUM_COORD; j++) begin : g_diff
    assign crd_diff[j*COORD_WIDTH +: COORD_WIDTH] =
      (Crd[j*COORD_WIDTH +: COORD_WIDTH] >= center[j*COORD_WIDTH +: COORD_WIDTH]) ?
      (Crd[j*COORD_WIDTH +: COORD_WIDTH] - center[j*COORD_WIDTH +: COORD_WIDTH]) :
      (center[j*COORD_WIDTH +: COORD_WIDTH] - Crd[j*COORD_WIDTH +: COORD_WIDTH]);
  end

  // Stage 1: capture differences, index and last flag. An empty slot
  // (no accept while enabled) moves forward as a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s1_idx  <= '0;
      s1_diff <= '0;
    end else if (en) begin
      s1_vld <= crd_fire;
      if (crd_fire) begin
        s1_last <= (rem == '0);
        s1_idx  <= idx;
        s1_diff <= crd_diff;
      end
    end
  end

  // Sum of squares at full width, then saturate into DIST_WIDTH bits.
  always_comb begin
    sum_ext = '0;
    for (int j = 0; j < NUM_COORD; j++) begin
      sum_ext = sum_ext +
        (EXT_W'(s1_diff[j*COORD_WIDTH +: COORD_WIDTH]) *
         EXT_W'(s1_diff[j*COORD_WIDTH +: COORD_WIDTH]));
    end
    dist_next = (sum_ext >= SAT_LIM) ? DIST_SAT : sum_ext[DIST_WIDTH-1:0];
  end

  // Stage 2: output register. It is frozen while the sorter holds back a
  // valid beat. Last is qualified by valid, so a bubble never carries it.
  always_ff @(posedge clk) begin
    if (rst) begin
      lop_vld  <= 1'b0;
      lop_last <= 1'b0;
      lop_idx  <= '0;
      lop_dist <= '0;
    end else if (en) begin
      lop_vld  <= s1_vld;
      lop_last <= s1_vld && s1_last;
      if (s1_vld) begin
        lop_idx  <= s1_idx;
        lop_dist <= dist_next;
      end
    end
  end

  assign SSCINS_Lop     = {lop_idx, lop_dist};
  assign SSCINS_LopVld  = lop_vld;
  assign SSCINS_LopLast = lop_last;
  assign Cmd_Rdy        = (state == ST_IDLE);
  assign Crd_Rdy        = (state == ST_RUN) && en;
  assign Busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_ssc_dist_stream.sv
// Testbench for ssc_dist_stream. Directed commands are expanded into expected
// {last, idx, dist} beats by a distance model written in plain integer
// arithmetic. One negedge process checks every output handshake against that
// queue, and the bench adds literal checks for the listed scenarios.
module tb_ssc_dist_stream;

  localparam int CW = 8;
  localparam int NC = 3;
  localparam int IW = 10;
  localparam int DW = 17;
  localparam int PW = CW * NC;
  localparam int LW = IW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          cmd_vld, cmd_rdy, crd_vld, crd_rdy;
  logic [PW-1:0] cmd_crd, crd;
  logic [IW-1:0] cmd_base, cmd_num;
  logic [LW-1:0] lop;
  logic          lop_vld, lop_last, lop_rdy, busy;

  ssc_dist_stream #(
    .COORD_WIDTH(CW), .NUM_COORD(NC), .IDX_WIDTH(IW), .DIST_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .Cmd_Vld(cmd_vld), .Cmd_Rdy(cmd_rdy), .Cmd_Crd(cmd_crd),
    .Cmd_BaseIdx(cmd_base), .Cmd_Num(cmd_num),
    .Crd_Vld(crd_vld), .Crd_Rdy(crd_rdy), .Crd(crd),
    .SSCINS_Lop(lop), .SSCINS_LopVld(lop_vld), .SSCINS_LopLast(lop_last),
    .SSCINS_LopRdy(lop_rdy), .Busy(busy)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  logic [LW:0]   exp_q[$];   // expected {last, idx, dist}
  logic [LW:0]   act_q[$];   // beats seen, for literal checks
  int            acc_q[$];   // accept cycle of each candidate
  logic [PW-1:0] cand[16];
  bit            lat_chk = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- model ----------------
  function automatic logic [PW-1:0] pt(input int x, input int y, input int z);
    return {z[CW-1:0], y[CW-1:0], x[CW-1:0]};
  endfunction

  function automatic int dist_of(input logic [PW-1:0] a, input logic [PW-1:0] b);
    int s;
    int d;
    s = 0;
    for (int j = 0; j < NC; j++) begin
      d = int'(a[j*CW +: CW]) - int'(b[j*CW +: CW]);
      s = s + d * d;
    end
    if (s >= (1 << DW) - 1) s = (1 << DW) - 2;
    return s;
  endfunction

  task automatic model_cmd(input logic [PW-1:0] ctr, input int base, input int num);
    logic [IW-1:0] iv;
    logic [DW-1:0] dv;
    int            t;
    for (int k = 0; k <= num; k++) begin
      t  = (base + k) % (1 << IW);
      iv = t[IW-1:0];
      t  = dist_of(cand[k], ctr);
      dv = t[DW-1:0];
      exp_q.push_back({(k == num), iv, dv});
    end
  endtask

  // ---------------- compare process ----------------
  logic        prev_stall = 1'b0;
  logic [LW:0] prev_beat;
  bit          idle_next  = 1'b0;

  always @(negedge clk) begin
    logic [LW:0] e;
    int          a;
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      prev_stall = 1'b0;
      idle_next  = 1'b0;
    end else begin
      if (idle_next) begin
        check("idle_after_last", {busy, cmd_rdy}, 2'b01);
        idle_next = 1'b0;
      end
      if (prev_stall)
        check("stall_hold", {lop_vld, lop_last, lop}, {1'b1, prev_beat});
      if (lop_vld && lop_rdy) begin
        act_q.push_back({lop_last, lop});
        if (exp_q.size() == 0) fail_now("extra_beat");
        else begin
          e = exp_q.pop_front();
          check("beat", {lop_last, lop}, e);
        end
        if (acc_q.size() > 0) begin
          a = acc_q.pop_front();
          if (lat_chk) check("latency", cyc - a, 2);
        end
        if (lop_last) idle_next = 1'b1;
      end
      prev_stall = lop_vld && !lop_rdy;
      prev_beat  = {lop_last, lop};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [PW-1:0] ctr, input int base, input int num);
    int n;
    bit done;
    cmd_crd  = ctr;
    cmd_base = base[IW-1:0];
    cmd_num  = num[IW-1:0];
    cmd_vld  = 1'b1;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (cmd_rdy) done = 1'b1;
      else if (++n > 100) begin fail_now("cmd_timeout"); done = 1'b1; end
    end
    @(posedge clk);
    #1;
    cmd_vld = 1'b0;
  endtask

  task automatic send_crd(input logic [PW-1:0] p);
    int n;
    bit done;
    crd     = p;
    crd_vld = 1'b1;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (crd_rdy) begin acc_q.push_back(cyc); done = 1'b1; end
      else if (++n > 100) begin fail_now("crd_timeout"); done = 1'b1; end
    end
    @(posedge clk);
    #1;
    crd_vld = 1'b0;
  endtask

  task automatic run_cmd(input logic [PW-1:0] ctr, input int base, input int num);
    model_cmd(ctr, base, num);
    send_cmd(ctr, base, num);
    for (int k = 0; k <= num; k++) send_crd(cand[k]);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || busy) && n < 200);
    if (exp_q.size() != 0 || busy) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_reset(input string name);
    check({name, "_lop"}, {lop_vld, lop_last, lop}, '0);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_cmd_rdy"}, cmd_rdy, 1'b1);
    check({name, "_crd_rdy"}, crd_rdy, 1'b0);
  endtask

  task automatic bp_ctrl();
    int n;
    bit done;
    logic [LW-1:0] want;
    want = {10'd6, 17'd25};
    n = 0;
    done = 1'b0;
    while (!done && n < 50) begin
      @(posedge clk);
      #1;
      n++;
      if (lop_vld && lop[LW-1:DW] == 10'd6) begin
        lop_rdy = 1'b0;
        repeat (5) begin
          @(posedge clk);
          #1;
          check("bp_crd_rdy", crd_rdy, 1'b0);
          check("bp_hold", {lop_vld, lop}, {1'b1, want});
        end
        lop_rdy = 1'b1;
        done = 1'b1;
      end
    end
    if (!done) fail_now("bp_timeout");
  endtask

  // ---------------- main sequence ----------------
  logic [LW:0] b;

  initial begin
    cmd_vld = 1'b0; cmd_crd = '0; cmd_base = '0; cmd_num = '0;
    crd_vld = 1'b0; crd = '0; lop_rdy = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_outputs_reset("reset");

    // Pin the model to hand-computed distances.
    check("model_9",   dist_of(pt(11, 2, 2), pt(10, 0, 0)), 9);
    check("model_25",  dist_of(pt(13, 0, 4), pt(10, 0, 0)), 25);
    check("model_0",   dist_of(pt(10, 0, 0), pt(10, 0, 0)), 0);
    check("model_sat", dist_of(pt(255, 255, 255), pt(0, 0, 0)), 131070);

    // Basic stream.
    @(posedge clk);
    #1;
    cand[0] = pt(11, 2, 2); cand[1] = pt(13, 0, 4); cand[2] = pt(10, 0, 0);
    act_q.delete();
    model_cmd(pt(10, 0, 0), 5, 2);
    send_cmd(pt(10, 0, 0), 5, 2);
    check("cmd_busy", busy, 1'b1);
    check("cmd_crd_rdy", crd_rdy, 1'b1);
    for (int k = 0; k <= 2; k++) send_crd(cand[k]);
    wait_drain();
    check("basic_count", act_q.size(), 3);
    if (act_q.size() == 3) begin
      b = act_q[0]; check("basic_b0", b, {1'b0, 10'd5, 17'd9});
      b = act_q[1]; check("basic_b1", b, {1'b0, 10'd6, 17'd25});
      b = act_q[2]; check("basic_b2", b, {1'b1, 10'd7, 17'd0});
    end

    // Saturation.
    act_q.delete();
    cand[0] = pt(255, 255, 255);
    run_cmd(pt(0, 0, 0), 3, 0);
    wait_drain();
    check("sat_count", act_q.size(), 1);
    if (act_q.size() == 1) begin
      b = act_q[0];
      check("sat_dist", b[DW-1:0], 17'd131070);
    end

    // Backpressure on the second beat.
    act_q.delete();
    lat_chk = 1'b0;
    cand[0] = pt(11, 2, 2); cand[1] = pt(13, 0, 4); cand[2] = pt(10, 0, 0);
    fork
      run_cmd(pt(10, 0, 0), 5, 2);
      bp_ctrl();
    join
    wait_drain();
    lat_chk = 1'b1;
    check("bp_count", act_q.size(), 3);
    if (act_q.size() == 3) begin
      b = act_q[0]; check("bp_b0", b, {1'b0, 10'd5, 17'd9});
      b = act_q[1]; check("bp_b1", b, {1'b0, 10'd6, 17'd25});
      b = act_q[2]; check("bp_b2", b, {1'b1, 10'd7, 17'd0});
    end

    // Index wrap.
    act_q.delete();
    cand[0] = pt(1, 1, 1); cand[1] = pt(2, 0, 0); cand[2] = pt(0, 3, 0); cand[3] = pt(200, 100, 50);
    run_cmd(pt(0, 0, 0), 1022, 3);
    wait_drain();
    check("wrap_count", act_q.size(), 4);
    if (act_q.size() == 4) begin
      b = act_q[0]; check("wrap_i0", b[LW-1:DW], 10'd1022);
      b = act_q[1]; check("wrap_i1", b[LW-1:DW], 10'd1023);
      b = act_q[2]; check("wrap_i2", b[LW-1:DW], 10'd0);
      b = act_q[3]; check("wrap_i3", b[LW:DW], {1'b1, 10'd1});
    end

    // Single-candidate command.
    act_q.delete();
    cand[0] = pt(5, 5, 5);
    run_cmd(pt(4, 4, 4), 9, 0);
    wait_drain();
    check("single_count", act_q.size(), 1);
    if (act_q.size() == 1) begin
      b = act_q[0];
      check("single_beat", b, {1'b1, 10'd9, 17'd3});
    end

    // Mid-stream reset after 2 of 4 candidates.
    cand[0] = pt(9, 9, 9); cand[1] = pt(8, 8, 8); cand[2] = pt(7, 7, 7); cand[3] = pt(6, 6, 6);
    model_cmd(pt(1, 1, 1), 100, 3);
    send_cmd(pt(1, 1, 1), 100, 3);
    send_crd(cand[0]);
    send_crd(cand[1]);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_outputs_reset("midrst");
    act_q.delete();
    @(posedge clk);
    #1;
    cand[0] = pt(4, 6, 3);
    run_cmd(pt(1, 2, 3), 50, 0);
    wait_drain();
    check("midrst_count", act_q.size(), 1);
    if (act_q.size() == 1) begin
      b = act_q[0];
      check("midrst_beat", b, {1'b1, 10'd50, 17'd25});
    end

    repeat (3) @(negedge clk);
    check("final_exp_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL global_timeout (t=%0t)", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ssc_dist_stream.md
# ssc_dist_stream

Distance-stream transmitter feeding the top-K insertion sorter. Per command, it takes one center point and a stream of candidate points. For each candidate it computes a saturated squared Euclidean distance and emits `{Idx, Dist}` beats on the `SSCINS_Lop` channel, asserting `SSCINS_LopLast` on the final candidate so the sorter closes its window. It sits between the point-fetch path and the sorter, on the producer end of the Lop handshake.

## Interface
Parameters:
- `COORD_WIDTH`, default 8: unsigned width of one coordinate.
- `NUM_COORD`, default 3: number of coordinates per point.
- `IDX_WIDTH`, default 10: point index width.
- `DIST_WIDTH`, default 17: width of the emitted distance.

Ports:
- `clk` input 1: the single clock.
- `rst` input 1: reset. One clock; reset is synchronous and active-high.
- `Cmd_Vld` input 1: command valid.
- `Cmd_Rdy` output 1: command ready; high only in IDLE.
- `Cmd_Crd` input `COORD_WIDTH*NUM_COORD`: center point; coordinate j is at bits `[COORD_WIDTH*j +: COORD_WIDTH]`.
- `Cmd_BaseIdx` input `IDX_WIDTH`: index of the first candidate.
- `Cmd_Num` input `IDX_WIDTH`: candidate count minus 1.
- `Crd_Vld` input 1: candidate valid.
- `Crd_Rdy` output 1: candidate ready.
- `Crd` input `COORD_WIDTH*NUM_COORD`: candidate point, same packing as `Cmd_Crd`.
- `SSCINS_Lop` output `IDX_WIDTH+DIST_WIDTH`: `{Idx, Dist}`, with Idx in the MSBs.
- `SSCINS_LopVld` output 1: Lop valid.
- `SSCINS_LopLast` output 1: marks the last beat of the command.
- `SSCINS_LopRdy` input 1: sorter ready.
- `Busy` output 1: high whenever state is not IDLE.

## Operation
- **FSM states:**
  - IDLE: `Cmd_Rdy=1`. Accepting a command latches the center, `Cnt=0`, `Idx=Cmd_BaseIdx`, `Rem=Cmd_Num`, then moves to RUN.
  - RUN: accepts candidates. On the handshake where `Rem==0`, moves to DRAIN. Otherwise decrements `Rem` and increments `Idx`.
  - DRAIN: no candidates are accepted. On the output handshake with `SSCINS_LopLast=1`, returns to IDLE.
- **Index rule:** `Idx` wraps modulo `2^IDX_WIDTH`.
- **Stage 1 (registered):**
  - Per-coordinate `|Crd_j - Center_j|`, `COORD_WIDTH` bits.
  - Carries `Idx`, a Last flag (`Rem==0`), and a valid bit.
- **Stage 2 (registered, drives the outputs):**
  - Squares each difference and sums them at full width: `2*COORD_WIDTH + clog2(NUM_COORD)` bits.
  - If the sum is `>= 2^DIST_WIDTH - 1`, outputs `Dist = 2^DIST_WIDTH - 2`.
  - All-ones is reserved as the sorter's "empty" value, so a saturated distance stays insertable.
- **Pipeline enable:**
  - `en = !SSCINS_LopVld | SSCINS_LopRdy`; both stages advance only when `en=1`.
  - `Crd_Rdy = (state==RUN) & en`.
- **Output behaviour:**
  - Bubbles propagate as valid=0.
  - `SSCINS_Lop`, `SSCINS_LopVld`, and `SSCINS_LopLast` stay stable while `SSCINS_LopVld & !SSCINS_LopRdy`.
  - When the sorter drops `SSCINS_LopRdy` while it holds its result, the whole pipe stalls with no loss and no duplication.
- **Reset (any cycle, including mid-stream):**
  - State goes to IDLE and both stage valids clear.
  - `SSCINS_Lop=0`, `SSCINS_LopVld=0`, `SSCINS_LopLast=0`, `Busy=0`.
  - Because `Cmd_Rdy` and `Crd_Rdy` are combinational from state, they read 1 and 0 after reset.

## Timing
- **Command:** accepted in cycle t, so `Busy=1` and `Crd_Rdy` can first be high in t+1.
- **Latency:** a candidate accepted in cycle t, with no stall, gives `SSCINS_LopVld=1` in cycle t+2.
- **Throughput:** one candidate per cycle when the sorter is always ready.
- **Return to IDLE:** after the last handshake in cycle t, the state is IDLE and `Cmd_Rdy=1` in t+1. A new command can be accepted that same cycle.
- **`SSCINS_LopLast`:** high on exactly one beat per command, including single-candidate commands (`Cmd_Num=0`).
- **Candidate side:** `Crd_Vld` asserted while `Crd_Rdy=0` is ignored. The candidate is held by the source.

## Test plan
- **Reset:** assert `rst` for 2 cycles, then check `Cmd_Rdy=1`, `Crd_Rdy=0`, `SSCINS_LopVld=0`, `Busy=0`.
- **Basic stream:** center (10,0,0), `Cmd_BaseIdx=5`, `Cmd_Num=2`, candidates (11,2,2), (13,0,4), (10,0,0), `SSCINS_LopRdy` held at 1.
  - Expect Lop beats {5,9}, {6,25}, {7,0}, each 2 cycles after its accept.
  - Last is set only on {7,0}; `Busy` falls the cycle after it.
- **Saturation:** center (0,0,0), candidate (255,255,255).
  - Raw sum is 195075; expect Dist=131070, not 131071.
- **Backpressure:** same stream as the basic test, with `SSCINS_LopRdy=0` for 5 cycles during the second beat.
  - Lop holds {6,25} stable and `Crd_Rdy=0` throughout.
  - Exactly 3 beats total, in order.
- **Index wrap and single-candidate command:**
  - `Cmd_BaseIdx=1022`, `Cmd_Num=3`: expect indices 1022, 1023, 0, 1.
  - Then `Cmd_Num=0`: expect one beat with Last=1.
- **Mid-stream reset:** assert `rst` after 2 of 4 candidates.
  - All outputs return to reset values.
  - A following command with 1 candidate produces exactly 1 correct beat.
